// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
//   Execute stage of a five-stage RISC pipeline. Holds the ID/EX pipeline
//   register and performs operand forwarding, ALU evaluation, branch target
//   computation and the branch/jump redirect decision.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   FlushE              inserts a bubble into the ID/EX register
//   *D control/data     decode-stage values captured into the E register
//   ForwardAE/BE        operand forwarding selects (00 reg, 01 WB, 10 MEM)
//   ALUResultM, ResultW forwarded results from the memory / writeback stages
//   RegWriteE .. PCPlus4E  registered values for later stages / hazard unit
//   ALUResultE, WriteDataE, PCTargetE, PCSrcE  combinational execute results
// -----------------------------------------------------------------------------
module execute_stage #(
  parameter int word_width = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  FlushE,
  input  logic                  RegWriteD,
  input  logic [1:0]            ResultSrcD,
  input  logic                  MemWriteD,
  input  logic                  JumpD,
  input  logic                  BranchD,
  input  logic [2:0]            ALUControlD,
  input  logic                  ALUSrcD,
  input  logic [word_width-1:0] RD1D,
  input  logic [word_width-1:0] RD2D,
  input  logic [word_width-1:0] PCD,
  input  logic [word_width-1:0] PCPlus4D,
  input  logic [31:0]           ImmExtD,
  input  logic [4:0]            Rs1D,
  input  logic [4:0]            Rs2D,
  input  logic [4:0]            RdD,
  input  logic [1:0]            ForwardAE,
  input  logic [1:0]            ForwardBE,
  input  logic [word_width-1:0] ALUResultM,
  input  logic [word_width-1:0] ResultW,
  output logic                  RegWriteE,
  output logic [1:0]            ResultSrcE,
  output logic                  MemWriteE,
  output logic [4:0]            RdE,
  output logic [4:0]            Rs1E,
  output logic [4:0]            Rs2E,
  output logic [word_width-1:0] PCPlus4E,
  output logic [word_width-1:0] ALUResultE,
  output logic [word_width-1:0] WriteDataE,
  output logic [word_width-1:0] PCTargetE,
  output logic                  PCSrcE
);

  // E-stage registers that are not exported directly
  logic                  JumpE;
  logic                  BranchE;
  logic [2:0]            ALUControlE;
  logic                  ALUSrcE;
  logic [word_width-1:0] RD1E;
  logic [word_width-1:0] RD2E;
  logic [word_width-1:0] PCE;
  logic [31:0]           ImmExtE;

  logic [word_width-1:0] imm_ext;
  logic [word_width-1:0] src_a;
  logic [word_width-1:0] src_b;
  logic                  zero;

  // Immediate is always 32 bits; sign-adapt it to the datapath width.
  assign imm_ext = word_width'($signed(ImmExtE));

  // ID/EX register: reset and flush both load an all-zero bubble
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      RegWriteE   <= 1'b0;
      ResultSrcE  <= 2'b00;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUControlE <= 3'b000;
      ALUSrcE     <= 1'b0;
      RD1E        <= '0;
      RD2E        <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      ImmExtE     <= 32'd0;
      Rs1E        <= 5'd0;
      Rs2E        <= 5'd0;
      RdE         <= 5'd0;
    end else begin
      RegWriteE   <= RegWriteD;
      ResultSrcE  <= ResultSrcD;
      MemWriteE   <= MemWriteD;
      JumpE       <= JumpD;
      BranchE     <= BranchD;
      ALUControlE <= ALUControlD;
      ALUSrcE     <= ALUSrcD;
      RD1E        <= RD1D;
      RD2E        <= RD2D;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      ImmExtE     <= ImmExtD;
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      RdE         <= RdD;
    end
  end

  // Operand A forwarding mux; 11 is reserved and falls back to the register value
  always_comb begin
    src_a = RD1E;
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUResultM;
      default: src_a = RD1E;
    endcase
  end

  // Operand B forwarding mux; the forwarded value is also the store data
  always_comb begin
    WriteDataE = RD2E;
    case (ForwardBE)
      2'b01:   WriteDataE = ResultW;
      2'b10:   WriteDataE = ALUResultM;
      default: WriteDataE = RD2E;
    endcase
  end

  // Second ALU operand: immediate or (forwarded) register
  always_comb begin
    if (ALUSrcE) begin
      src_b = imm_ext;
    end else begin
      src_b = WriteDataE;
    end
  end

  // ALU; add/sub wrap silently, unused codes yield zero
  always_comb begin
    ALUResultE = '0;
    case (ALUControlE)
      3'b000:  ALUResultE = src_a + src_b;
      3'b001:  ALUResultE = src_a - src_b;
      3'b010:  ALUResultE = src_a & src_b;
      3'b011:  ALUResultE = src_a | src_b;
      3'b101:  ALUResultE = ($signed(src_a) < $signed(src_b)) ? word_width'(1) : '0;
      default: ALUResultE = '0;
    endcase
  end

  assign zero      = (ALUResultE == '0);
  assign PCTargetE = PCE + imm_ext;
  // A bubble has JumpE=BranchE=0, so it can never redirect fetch.
  assign PCSrcE    = JumpE | (BranchE & zero);

endmodule
